// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command issuer.
//   - 3-bit ALU op encodings (OP_ZERO..OP_SUB); bit 3 of a 4-bit op marks it illegal
//   - issuer FSM state type
//   - data width and the queued command record {op, a, b, acc}
// Optional feature macro used by the consumers of this package: ALU_CMD_ISSUER_ACC_EN.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_NOTA = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              acc;
  } cmd_t;

  // An op with bit 3 set has no ALU meaning and is answered with an error.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding queued ALU commands.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears pointers/count)
//   push, wr_data   - write request and data; accepted when not full, or when
//                     a pop happens in the same cycle
//   pop, rd_data    - read request; rd_data always shows the head entry
//   full, empty     - occupancy flags, derived from the registered count
// Parameters: WIDTH (entry bits), DEPTH (entries, power of two).
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == CNT_ZERO);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; a pop frees the slot a same-cycle push uses.
  always_comb begin
    pop_ok_s  = pop & !empty;
    push_ok_s = push & (!full | pop_ok_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: sequential initiator for the combinational 32-bit ALU.
// Commands arrive on cmd_valid/cmd_ready, queue in cmd_fifo, are issued one at a
// time on alu_a/alu_b/alu_op, and after ALU_LAT cycles the ALU result is returned
// on rsp_valid/rsp_ready with zero/neg/err flags.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   cmd_valid/cmd_ready           - command handshake (ready = FIFO not full)
//   cmd_op/cmd_a/cmd_b/cmd_acc    - command fields (cmd_acc only with the macro)
//   alu_a/alu_b/alu_op            - registered ALU operand/op drive
//   alu_result                    - ALU output
//   rsp_valid/rsp_ready           - response handshake
//   rsp_result/rsp_zero/rsp_neg/rsp_err - response fields, held until accepted
//   busy                          - FSM not idle or commands queued
// Parameters: FIFO_DEPTH (2..16, power of two), ALU_LAT (1..15).
// Optional feature: define ALU_CMD_ISSUER_ACC_EN to add a result accumulator
// that a command with cmd_acc=1 uses in place of cmd_a.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         CMD_W    = $bits(cmd_t);
  localparam logic [3:0] LAT_M1   = 4'(ALU_LAT - 1);
  localparam logic [3:0] CNT_ZERO = 4'd0;
  localparam logic [3:0] CNT_ONE  = 4'd1;

  cmd_t              push_cmd_s;
  cmd_t              head_cmd_s;
  logic              push_s, pop_s, full_s, empty_s;

  state_e            state_q, state_d;
  cmd_t              opr_q, opr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_neg_q, rsp_neg_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] issue_a_s;

`ifdef ALU_CMD_ISSUER_ACC_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`else
  logic              unused_acc_s;
  assign unused_acc_s = cmd_acc ^ opr_q.acc;
`endif

  assign cmd_ready = !full_s;
  assign push_s    = cmd_valid & !full_s;
  assign busy      = (state_q != ST_IDLE) | !empty_s;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_neg    = rsp_neg_q;
  assign rsp_err    = rsp_err_q;

  // Pack the incoming command; the acc flag is only kept when the accumulator exists.
  always_comb begin
    push_cmd_s.op = cmd_op;
    push_cmd_s.a  = cmd_a;
    push_cmd_s.b  = cmd_b;
`ifdef ALU_CMD_ISSUER_ACC_EN
    push_cmd_s.acc = cmd_acc;
`else
    push_cmd_s.acc = 1'b0;
`endif
  end

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .wr_data (push_cmd_s),
    .pop     (pop_s),
    .rd_data (head_cmd_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Operand A at issue: the accumulator substitutes for cmd_a so chained commands
  // see the result captured just before this issue.
  always_comb begin
`ifdef ALU_CMD_ISSUER_ACC_EN
    if (opr_q.acc) begin
      issue_a_s = acc_q;
    end else begin
      issue_a_s = opr_q.a;
    end
`else
    issue_a_s = opr_q.a;
`endif
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    opr_d        = opr_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_err_d    = rsp_err_q;
    pop_s        = 1'b0;
`ifdef ALU_CMD_ISSUER_ACC_EN
    acc_d        = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          opr_d   = head_cmd_s;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (op_is_illegal(opr_q.op)) begin
          // ALU drive is left untouched so its inputs stay at the last legal command.
          rsp_result_d = '0;
          rsp_zero_d   = 1'b1;
          rsp_neg_d    = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          alu_a_d  = issue_a_s;
          alu_b_d  = opr_q.b;
          alu_op_d = opr_q.op;
          cnt_d    = LAT_M1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = (alu_result == 32'h0000_0000);
          rsp_neg_d    = alu_result[DATA_W-1];
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
`ifdef ALU_CMD_ISSUER_ACC_EN
          acc_d        = alu_result;
`endif
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty_s) begin
            pop_s   = 1'b1;
            opr_d   = head_cmd_s;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, operand, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      opr_q        <= '0;
      cnt_q        <= 4'd0;
      alu_a_q      <= 32'h0000_0000;
      alu_b_q      <= 32'h0000_0000;
      alu_op_q     <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'h0000_0000;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_CMD_ISSUER_ACC_EN
      acc_q        <= 32'h0000_0000;
`endif
    end else begin
      state_q      <= state_d;
      opr_q        <= opr_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_CMD_ISSUER_ACC_EN
      acc_q        <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU attached.
// Table of single-command vectors plus directed sequences for backpressure,
// mid-operation reset and (with ALU_CMD_ISSUER_ACC_EN) accumulator chaining.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

`ifdef ALU_CMD_ISSUER_ACC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_acc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_neg;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_cmd_issuer #(.FIFO_DEPTH(4), .ALU_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_acc    (cmd_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    if (alu_op[3]) begin
      alu_result = 32'h0;
    end else begin
      case (alu_op[2:0])
        OP_ZERO: alu_result = 32'h0;
        OP_NOTA: alu_result = ~alu_a;
        OP_AND:  alu_result = alu_a & alu_b;
        OP_OR:   alu_result = alu_a | alu_b;
        OP_XOR:  alu_result = alu_a ^ alu_b;
        OP_XNOR: alu_result = ~(alu_a ^ alu_b);
        OP_ADD:  alu_result = alu_a + alu_b;
        OP_SUB:  alu_result = alu_a - alu_b;
        default: alu_result = 32'h0;
      endcase
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Offer one command; returns ok=1 once the edge accepting it has passed.
  task automatic push_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic acc, output bit ok);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    cmd_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    cmd_acc   = 1'b0;
  endtask

  // Step until rsp_valid is seen; n = cycles stepped.
  task automatic wait_rsp(output bit seen, output int n);
    n    = 0;
    seen = rsp_valid;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = rsp_valid;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    bit          ok;
    bit          seen;
    int          n;
    int          cnt;
    logic [3:0]  last_op;

    vecs[0]  = '{4'b0110, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0111, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0111, 32'h1234,       32'h1234,       32'h0,          1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 32'h0F0F_0F0F,  32'h1234_5678,  32'hF0F0_F0F0,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0010, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0011, 32'hFF00_0000,  32'h0000_00FF,  32'hFF00_00FF,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b0100, 32'hAAAA_AAAA,  32'h5555_5555,  32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{4'b0101, 32'hAAAA_AAAA,  32'h5555_5555,  32'h0,          1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b1000, 32'h11,         32'h22,         32'h0,          1'b1, 1'b0, 1'b1};
    vecs[9]  = '{4'b0110, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0000, 32'hDEAD_BEEF,  32'h1,          32'h0,          1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'b0110, 32'h7FFF_FFFF,  32'h1,          32'h8000_0000,  1'b0, 1'b1, 1'b0};

    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 32'h0;
    cmd_b     = 32'h0;
    cmd_acc   = 1'b0;
    rsp_ready = 1'b0;
    reset     = 1'b0;
    do_reset();

    // Reset state
    check("rst_cmd_ready",  cmd_ready,  1);
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_busy",       busy,       0);
    check("rst_alu_a",      alu_a,      0);
    check("rst_alu_op",     alu_op,     0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err",    rsp_err,    0);

    // Single-command vectors from idle
    last_op = 4'd0;
    for (int i = 0; i < 12; i++) begin
      push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, ok);
      check($sformatf("v%0d_push", i), ok, 1);
      wait_rsp(seen, n);
      check($sformatf("v%0d_seen", i), seen, 1);
      check($sformatf("v%0d_latency", i), n, vecs[i].err ? 2 : LAT + 2);
      check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("v%0d_zero", i), rsp_zero, vecs[i].zero);
      check($sformatf("v%0d_neg", i), rsp_neg, vecs[i].neg);
      check($sformatf("v%0d_err", i), rsp_err, vecs[i].err);
      if (!vecs[i].err) begin
        last_op = vecs[i].op;
        check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
      end
      check($sformatf("v%0d_alu_op", i), alu_op, last_op);
      consume();
      check($sformatf("v%0d_valid_drop", i), rsp_valid, 0);
      check($sformatf("v%0d_busy_drop", i), busy, 0);
    end

    // Backpressure: 1 in flight + 4 queued fills the issuer
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_cmd(4'b0110, 32'd100 + k, k, 1'b0, ok);
      check($sformatf("bp_push%0d", k), ok, 1);
    end
    check("bp_full_ready", cmd_ready, 0);
    check("bp_full_busy", busy, 1);
    cmd_op    = 4'b0110;
    cmd_a     = 32'd300;
    cmd_b     = 32'd0;
    cmd_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (cmd_ready) cnt++;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_blocked", cnt, 0);
    for (int k = 0; k < 5; k++) begin
      wait_rsp(seen, n);
      check($sformatf("bp_seen%0d", k), seen, 1);
      if (k > 0) check($sformatf("bp_b2b_gap%0d", k), n, LAT + 1);
      check($sformatf("bp_result%0d", k), rsp_result, 32'd100 + 2 * k);
      consume();
    end
    check("bp_ready_back", cmd_ready, 1);
    push_cmd(4'b0110, 32'd200, 32'd5, 1'b0, ok);
    check("bp_resume_push", ok, 1);
    wait_rsp(seen, n);
    check("bp_resume_seen", seen, 1);
    check("bp_resume_result", rsp_result, 205);
    consume();

    // Reset during WAIT with two commands queued
    push_cmd(4'b0110, 32'd1, 32'd1, 1'b0, ok);
    push_cmd(4'b0110, 32'd2, 32'd2, 1'b0, ok);
    push_cmd(4'b0110, 32'd3, 32'd3, 1'b0, ok);
    check("mr_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_cmd_ready", cmd_ready, 1);
    check("mr_busy", busy, 0);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (rsp_valid) cnt++;
      tick();
    end
    rsp_ready = 1'b0;
    check("mr_no_stale", cnt, 0);
    check("mr_busy_after", busy, 0);

`ifdef ALU_CMD_ISSUER_ACC_EN
    // Accumulator chaining
    do_reset();
    push_cmd(4'b0110, 32'd10, 32'd1, 1'b0, ok);
    wait_rsp(seen, n);
    check("acc_lat0", n, LAT + 2);
    check("acc_res0", rsp_result, 11);
    consume();
    push_cmd(4'b0110, 32'hDEAD, 32'd1, 1'b1, ok);
    wait_rsp(seen, n);
    check("acc_lat1", n, LAT + 2);
    check("acc_res1", rsp_result, 12);
    consume();
    push_cmd(4'b1000, 32'd0, 32'd0, 1'b0, ok);
    wait_rsp(seen, n);
    check("acc_err", rsp_err, 1);
    consume();
    push_cmd(4'b0110, 32'd0, 32'd5, 1'b1, ok);
    push_cmd(4'b0110, 32'd0, 32'd5, 1'b1, ok);
    wait_rsp(seen, n);
    check("acc_chain0", rsp_result, 17);
    consume();
    wait_rsp(seen, n);
    check("acc_chain_gap", n, LAT + 1);
    check("acc_chain1", rsp_result, 22);
    consume();
`else
    // cmd_acc has no effect without the accumulator
    do_reset();
    push_cmd(4'b0110, 32'd3, 32'd4, 1'b1, ok);
    wait_rsp(seen, n);
    check("noacc_seen", seen, 1);
    check("noacc_result", rsp_result, 7);
    consume();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
